// File: rtl/dmem_resp_pkg.sv
// Shared definitions for the data-memory responder: bus widths, access-size
// encodings and the init/ready state encoding.
package dmem_resp_pkg;

    localparam int DMEM_DATA_WIDTH     = 32;
    localparam int CPU_DMEM_ADDR_WIDTH = 12;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

    typedef enum logic {
        S_INIT  = 1'b0,
        S_READY = 1'b1
    } state_t;

endpackage

// File: rtl/dmem_resp_lane_align.sv
// Byte-lane steering for dmem_resp: byte enables, masked write word, alignment
// check and the zero-extending read extract for the addressed lanes.
module dmem_lane_align
    import dmem_resp_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] word,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic        misalign,
    output logic [31:0] rdata
);

    always_comb begin
        be       = 4'b0000;
        misalign = 1'b0;
        rdata    = word;
        case (size)
            MEM_SIZE_BYTE: begin
                be    = 4'b0001 << off;
                rdata = {24'b0, word[8*off +: 8]};
            end
            MEM_SIZE_HALF: begin
                misalign = off[0];
                be       = off[1] ? 4'b1100 : 4'b0011;
                rdata    = {16'b0, word[16*off[1] +: 16]};
            end
            MEM_SIZE_WORD: begin
                misalign = |off;
                be       = 4'b1111;
            end
            default: begin
                // Reserved size behaves as a word access but is always rejected.
                misalign = 1'b1;
                be       = 4'b1111;
            end
        endcase
    end

    // Initiators already lane-position the data; only enabled lanes are kept.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            wword[8*i +: 8] = be[i] ? wdata[8*i +: 8] : 8'h00;
        end
    end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: word array with byte/half/word access, post-reset zero
// fill, sticky misalignment flag. Optional counters under DMEM_PERF_CNT_EN.
module dmem_resp
    import dmem_resp_pkg::*;
#(
    parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
    parameter int ADDR_WIDTH = CPU_DMEM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_rd,
    input  logic                  mem_wr,
    input  logic [1:0]            mem_size,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  ready,
    input  logic                  clr_err,
    output logic                  misalign_err
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [31:0]           rd_count,
    output logic [31:0]           wr_count
`endif
);

    localparam int IW    = ADDR_WIDTH - 2;
    localparam int DEPTH = 1 << IW;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    state_t                state;
    logic [IW-1:0]         init_idx;
    logic [IW-1:0]         idx;
    logic [3:0]            be;
    logic [DATA_WIDTH-1:0] wword;
    logic [DATA_WIDTH-1:0] rd_ext;
    logic                  mis;
    logic                  active;
    logic                  rd_ok;
    logic                  wr_ok;

    assign idx    = mem_addr[ADDR_WIDTH-1:2];
    assign active = (state == S_READY) && !rst;
    assign rd_ok  = active && mem_rd && !mis;
    assign wr_ok  = active && mem_wr && !mis;

    dmem_lane_align u_align (
        .size     (mem_size),
        .off      (mem_addr[1:0]),
        .wdata    (mem_wdata),
        .word     (mem[idx]),
        .be       (be),
        .wword    (wword),
        .misalign (mis),
        .rdata    (rd_ext)
    );

    // Array has no reset so contents survive rst; init overwrites them with zeros.
    always_ff @(posedge clk) begin
        if (!rst && state == S_INIT) begin
            mem[init_idx] <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_INIT;
            init_idx     <= '0;
            ready        <= 1'b0;
            mem_rdata    <= '0;
            misalign_err <= 1'b0;
        end else if (state == S_INIT) begin
            init_idx <= init_idx + 1'b1;
            if (init_idx == IW'(DEPTH - 1)) begin
                state <= S_READY;
                ready <= 1'b1;
            end
        end else begin
            if (mem_rd) mem_rdata <= mis ? '0 : rd_ext;
            if ((mem_rd || mem_wr) && mis) misalign_err <= 1'b1;
            else if (clr_err)              misalign_err <= 1'b0;
        end
    end

`ifdef DMEM_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (rd_ok) rd_count <= rd_count + 32'd1;
            if (wr_ok) wr_count <= wr_count + 32'd1;
        end
    end
`else
    logic unused_ok;
    assign unused_ok = rd_ok ^ wr_ok;
`endif

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: init timing, vector table through a
// read scoreboard, burst reads, reset restart and optional counters.
module tb_dmem_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_rdata;
    logic        ready;
    logic        clr_err;
    logic        misalign_err;
`ifdef DMEM_PERF_CNT_EN
    logic [31:0] rd_count;
    logic [31:0] wr_count;
`endif

    dmem_resp dut (
        .clk          (clk),
        .rst          (rst),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_rdata    (mem_rdata),
        .ready        (ready),
        .clr_err      (clr_err),
        .misalign_err (misalign_err)
`ifdef DMEM_PERF_CNT_EN
        ,
        .rd_count     (rd_count),
        .wr_count     (wr_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic        clr;
        logic [11:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t        vt[28];
    logic [31:0] exp_q[$];
    logic [31:0] last_rd;
    int          n_cmp;
    int          n_fail;
    int          c_rd;
    int          c_wr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic mis_of(input logic [1:0] sz, input logic [11:0] a);
        case (sz)
            2'b00:   return 1'b0;
            2'b01:   return a[0];
            2'b10:   return |a[1:0];
            default: return 1'b1;
        endcase
    endfunction

    function automatic vec_t mk(input logic rd, input logic wr, input logic clr,
                                input logic [11:0] a, input logic [1:0] sz,
                                input logic [31:0] wd, input logic [31:0] er,
                                input logic ee);
        vec_t v;
        v.rd = rd; v.wr = wr; v.clr = clr; v.addr = a; v.size = sz;
        v.wdata = wd; v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    // One request cycle; inputs drive after #1, outputs checked #1 after the edge.
    task automatic step(input logic rd, input logic wr, input logic clr,
                        input logic [11:0] a, input logic [1:0] sz,
                        input logic [31:0] wd, input logic [31:0] er, input logic ee);
        logic [31:0] e;
        mem_rd = rd; mem_wr = wr; clr_err = clr;
        mem_addr = a; mem_size = sz; mem_wdata = wd;
        if (rd) exp_q.push_back(er);
        if (!mis_of(sz, a)) begin
            if (rd) c_rd++;
            if (wr) c_wr++;
        end
        @(posedge clk); #1;
        mem_rd = 1'b0; mem_wr = 1'b0; clr_err = 1'b0;
        if (rd) begin
            e = exp_q.pop_front();
            chk("rdata", mem_rdata, e);
            last_rd = e;
        end else begin
            chk("rdata_hold", mem_rdata, last_rd);
        end
        chk("misalign_err", {31'b0, misalign_err}, {31'b0, ee});
    endtask

    task automatic wait_init(input string nm);
        int cnt;
        cnt = 0;
        while (ready !== 1'b1 && cnt < 1100) begin
            mem_rd = 1'b1; mem_wr = 1'b1; mem_size = 2'b10; mem_wdata = 32'hFFFF_FFFF;
            mem_addr = (cnt % 2 == 1) ? 12'h001 : 12'h000;
            @(posedge clk); #1;
            cnt++;
            if (mem_rdata !== 32'h0 || misalign_err !== 1'b0)
                chk({nm, "_ignored"}, {mem_rdata[30:0], misalign_err}, 32'h0);
        end
        mem_rd = 1'b0; mem_wr = 1'b0;
        chk({nm, "_cycles"}, cnt, 32'd1024);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0; n_fail = 0; c_rd = 0; c_wr = 0; last_rd = 32'h0;
        rst = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; clr_err = 1'b0;
        mem_addr = '0; mem_size = '0; mem_wdata = '0;

        vt[0]  = mk(0, 1, 0, 12'h010, 2'b10, 32'h1122_3344, 32'h0, 0);
        vt[1]  = mk(0, 1, 0, 12'h012, 2'b00, 32'hAAAA_AAAA, 32'h0, 0);
        vt[2]  = mk(1, 0, 0, 12'h010, 2'b10, 32'h0, 32'h11AA_3344, 0);
        vt[3]  = mk(1, 0, 0, 12'h012, 2'b00, 32'h0, 32'h0000_00AA, 0);
        vt[4]  = mk(1, 0, 0, 12'h013, 2'b00, 32'h0, 32'h0000_0011, 0);
        vt[5]  = mk(1, 0, 0, 12'h012, 2'b01, 32'h0, 32'h0000_11AA, 0);
        vt[6]  = mk(0, 1, 0, 12'h022, 2'b01, 32'hBEEF_BEEF, 32'h0, 0);
        vt[7]  = mk(1, 0, 0, 12'h020, 2'b10, 32'h0, 32'hBEEF_0000, 0);
        vt[8]  = mk(1, 0, 0, 12'h022, 2'b01, 32'h0, 32'h0000_BEEF, 0);
        vt[9]  = mk(1, 0, 0, 12'h020, 2'b01, 32'h0, 32'h0000_0000, 0);
        vt[10] = mk(0, 1, 0, 12'h031, 2'b10, 32'hDEAD_BEEF, 32'h0, 1);
        vt[11] = mk(1, 0, 0, 12'h030, 2'b10, 32'h0, 32'h0000_0000, 1);
        vt[12] = mk(1, 0, 0, 12'h032, 2'b10, 32'h0, 32'h0000_0000, 1);
        vt[13] = mk(0, 0, 1, 12'h000, 2'b10, 32'h0, 32'h0, 0);
        vt[14] = mk(0, 1, 0, 12'h040, 2'b10, 32'h0000_0001, 32'h0, 0);
        vt[15] = mk(1, 1, 0, 12'h040, 2'b10, 32'h0000_0002, 32'h0000_0001, 0);
        vt[16] = mk(1, 0, 0, 12'h040, 2'b10, 32'h0, 32'h0000_0002, 0);
        vt[17] = mk(0, 1, 0, 12'h040, 2'b11, 32'h0000_0099, 32'h0, 1);
        vt[18] = mk(1, 0, 1, 12'h040, 2'b10, 32'h0, 32'h0000_0002, 0);
        vt[19] = mk(1, 0, 1, 12'h040, 2'b11, 32'h0, 32'h0000_0000, 1);
        vt[20] = mk(1, 0, 0, 12'h011, 2'b01, 32'h0, 32'h0000_0000, 1);
        vt[21] = mk(0, 0, 1, 12'h000, 2'b00, 32'h0, 32'h0, 0);
        vt[22] = mk(0, 1, 0, 12'h042, 2'b01, 32'h1234_5678, 32'h0, 0);
        vt[23] = mk(1, 0, 0, 12'h040, 2'b10, 32'h0, 32'h1234_0002, 0);
        vt[24] = mk(0, 1, 0, 12'h041, 2'b00, 32'h0000_C300, 32'h0, 0);
        vt[25] = mk(1, 0, 0, 12'h040, 2'b10, 32'h0, 32'h1234_C302, 0);
        vt[26] = mk(1, 0, 0, 12'h041, 2'b00, 32'h0, 32'h0000_00C3, 0);
        vt[27] = mk(1, 0, 0, 12'h3FC, 2'b10, 32'h0, 32'h0000_0000, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, ready}, 32'h0);
        chk("rst_rdata", mem_rdata, 32'h0);
        chk("rst_err", {31'b0, misalign_err}, 32'h0);
`ifdef DMEM_PERF_CNT_EN
        chk("rst_rd_count", rd_count, 32'h0);
        chk("rst_wr_count", wr_count, 32'h0);
`endif
        rst = 1'b0;
        wait_init("init");

        // Word 0 must still be zero: writes during init are ignored.
        step(1, 0, 0, 12'h000, 2'b10, 32'h0, 32'h0, 0);
        step(1, 0, 0, 12'h7A4, 2'b10, 32'h0, 32'h0, 0);

        for (int i = 0; i < 28; i++) begin
            step(vt[i].rd, vt[i].wr, vt[i].clr, vt[i].addr, vt[i].size,
                 vt[i].wdata, vt[i].exp_rdata, vt[i].exp_err);
        end
        step(0, 0, 0, 12'h000, 2'b00, 32'h0, 32'h0, 0);

        // Burst: four words written, then read on four consecutive cycles.
        for (int i = 0; i < 4; i++)
            step(0, 1, 0, 12'h050 + 12'(4*i), 2'b10, 32'hA000_0000 + i, 32'h0, 0);
        for (int i = 0; i < 4; i++)
            step(1, 0, 0, 12'h050 + 12'(4*i), 2'b10, 32'h0, 32'hA000_0000 + i, 0);
`ifdef DMEM_PERF_CNT_EN
        chk("rd_count", rd_count, 32'(c_rd));
        chk("wr_count", wr_count, 32'(c_wr));
`endif

        // Reset in the middle of activity restarts the zero fill.
        step(1, 0, 0, 12'h051, 2'b10, 32'h0, 32'h0, 1);
        rst = 1'b1; mem_wr = 1'b1; mem_addr = 12'h070; mem_size = 2'b10;
        mem_wdata = 32'h5A5A_5A5A;
        @(posedge clk); #1;
        rst = 1'b0; mem_wr = 1'b0;
        chk("rst2_ready", {31'b0, ready}, 32'h0);
        chk("rst2_err", {31'b0, misalign_err}, 32'h0);
        chk("rst2_rdata", mem_rdata, 32'h0);
        last_rd = 32'h0; c_rd = 0; c_wr = 0;
        wait_init("reinit");
        step(1, 0, 0, 12'h010, 2'b10, 32'h0, 32'h0, 0);
        step(1, 0, 0, 12'h070, 2'b10, 32'h0, 32'h0, 0);
`ifdef DMEM_PERF_CNT_EN
        chk("rd_count_after_rst", rd_count, 32'(c_rd));
        chk("wr_count_after_rst", wr_count, 32'(c_wr));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
